seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, from the LSB chunk upward. A carry register links consecutive chunks. This trades latency for a short combinational carry chain. It is the clocked successor of the team's 4-bit ripple-carry adder for datapaths wider than one chain can close timing on, and it adds subtract mode, signed overflow and a start/done handshake.

---
 rtl/adder_pkg.sv | 11 +
 rtl/chunk_adder.sv | 39 +++
 rtl/fulladder.sv | 17 +
 rtl/seq_chunk_adder.sv | 125 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunked adder family.
// Holds the FSM state encoding used by seq_chunk_adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple-carry adder built from fulladder cells.
// Ports:
//   a, b   : W-bit addends
//   cin    : carry into bit 0
//   sum    : W-bit sum
//   cout   : carry out of bit W-1
//   c_msb  : carry into bit W-1 (used for signed overflow detection)
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  // carry chain: c[i] is the carry into bit i, c[W] the carry out
  logic [W:0] c;

  assign c[0] = cin;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      fulladder u_fa (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (c[gi]),
        .s  (sum[gi]),
        .co (c[gi+1])
      );
    end
  endgenerate

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/fulladder.sv
// Single-bit full adder cell, the building block of the ripple chains.
// Ports:
//   a, b, ci : addend bits and carry in
//   s        : sum bit
//   co       : carry out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor. Operands are processed CHUNK bits per clock,
// LSB chunk first, with a carry register linking consecutive chunks, so the
// combinational carry chain is only CHUNK bits long.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   sub      : 0 -> a+b+cin, 1 -> a-b-cin (cin is a borrow-in)
//   a, b, cin: operands, sampled on the accepting edge only
//   busy     : high while an operation is running
//   done     : one-cycle pulse when sum/cout/ovf are valid
//   sum      : result, held until the next accepted start
//   cout     : carry out of MSB (for subtract, 1 means no borrow)
//   ovf      : signed overflow
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a multiple of CHUNK
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             cout_reg;
  logic             ovf_reg;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout;
  logic             chunk_cmsb;

  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] sum_next;

  chunk_adder #(.W(CHUNK)) u_chunk (
    .a     (a_reg[CHUNK-1:0]),
    .b     (b_reg[CHUNK-1:0]),
    .cin   (carry_reg),
    .sum   (chunk_sum),
    .cout  (chunk_cout),
    .c_msb (chunk_cmsb)
  );

  // Shift-right-by-CHUNK views; the single-chunk case has nothing left to shift.
  generate
    if (CHUNK == WIDTH) begin : g_single
      assign a_next   = '0;
      assign b_next   = '0;
      assign sum_next = chunk_sum;
    end else begin : g_multi
      assign a_next   = {{CHUNK{1'b0}}, a_reg[WIDTH-1:CHUNK]};
      assign b_next   = {{CHUNK{1'b0}}, b_reg[WIDTH-1:CHUNK]};
      assign sum_next = {chunk_sum, sum_reg[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            // subtract is a + ~b + 1; a borrow-in cancels the +1
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry_reg <= cin ^ sub;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          a_reg     <= a_next;
          b_reg     <= b_next;
          sum_reg   <= sum_next;
          carry_reg <= chunk_cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(NCHUNK - 1)) begin
            // last chunk holds the operand MSB
            cout_reg  <= chunk_cout;
            ovf_reg   <= chunk_cout ^ chunk_cmsb;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench for seq_chunk_adder. Three instances share the
// operand buses: CHUNK=4 (main), CHUNK=16 and CHUNK=1, all with WIDTH=16.
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sub = 1'b0;
  logic        cin = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  start_v = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [15:0] sum_v [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One operation on instance idx; operands are scrambled after the accepting
  // edge so only the sampled values may influence the result.
  task automatic run_op(input int idx, input string tag,
                        input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input int lat_exp, input bit poke);
    int lat;
    int busy_bad;
    lat = 0;
    busy_bad = 0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[idx] = 1'b0;
    a = ~ta; b = ~tb_v; cin = ~tcin;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (done_v[idx]) break;
      if (!busy_v[idx]) busy_bad++;
      if (poke && lat == 1) begin
        start_v[idx] = 1'b1;
        a = 16'h5555; b = 16'h5555;
      end else begin
        start_v[idx] = 1'b0;
      end
    end
    start_v[idx] = 1'b0;
    $display("op %s: a=0x%04h b=0x%04h cin=%0b sub=%0b -> sum=0x%04h cout=%0b ovf=%0b lat=%0d",
             tag, ta, tb_v, tcin, tsub, sum_v[idx], cout_v[idx], ovf_v[idx], lat);
    check({tag, " latency"}, lat, lat_exp);
    check({tag, " busy_in_run"}, busy_bad, 0);
    check({tag, " busy_at_done"}, busy_v[idx], 1'b0);
    check({tag, " sum"}, sum_v[idx], es);
    check({tag, " cout"}, cout_v[idx], ec);
    check({tag, " ovf"}, ovf_v[idx], eo);
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, done_v[idx], 1'b0);
    check({tag, " idle_busy"}, busy_v[idx], 1'b0);
    check({tag, " sum_held"}, sum_v[idx], es);
  endtask

  initial begin
    int done_cnt;

    // reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset busy%0d", i), busy_v[i], 1'b0);
      check($sformatf("reset done%0d", i), done_v[i], 1'b0);
      check($sformatf("reset sum%0d", i), sum_v[i], 16'h0000);
      check($sformatf("reset cout%0d", i), cout_v[i], 1'b0);
      check($sformatf("reset ovf%0d", i), ovf_v[i], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // CHUNK=4 directed vectors
    run_op(0, "add_basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 4, 1'b0);
    run_op(0, "add_carry",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
    run_op(0, "add_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, 1'b0);
    run_op(0, "add_cin",     16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 4, 1'b0);
    run_op(0, "sub_neg",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, 1'b0);
    run_op(0, "sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, 1'b0);
    run_op(0, "sub_borrow",  16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 4, 1'b0);
    run_op(0, "start_in_run",16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 4, 1'b1);

    // back-to-back: start held high through DONE, second operands applied during RUN
    run_op(0, "pre_b2b",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b first wait%0d done", i), done_v[0], 1'b0);
    end
    @(posedge clk);
    #1;
    check("b2b first done", done_v[0], 1'b1);
    check("b2b first sum", sum_v[0], 16'h2233);
    check("b2b first cout", cout_v[0], 1'b0);
    $display("op b2b_first: sum=0x%04h cout=%0b ovf=%0b", sum_v[0], cout_v[0], ovf_v[0]);
    @(posedge clk);
    #1;
    check("b2b second accepted busy", busy_v[0], 1'b1);
    check("b2b second accepted done", done_v[0], 1'b0);
    @(negedge clk);
    start_v[0] = 1'b0;
    a = 16'h0000; b = 16'h0000;
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    check("b2b second done", done_v[0], 1'b1);
    check("b2b second sum", sum_v[0], 16'h8000);
    check("b2b second ovf", ovf_v[0], 1'b1);
    $display("op b2b_second: sum=0x%04h cout=%0b ovf=%0b", sum_v[0], cout_v[0], ovf_v[0]);

    // reset mid-RUN after a result with cout=1 is held
    run_op(0, "pre_abort",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, 1'b0);
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort busy", busy_v[0], 1'b0);
    check("abort done", done_v[0], 1'b0);
    check("abort sum", sum_v[0], 16'h0000);
    check("abort cout", cout_v[0], 1'b0);
    check("abort ovf", ovf_v[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done_v[0] || busy_v[0]) done_cnt++;
    end
    check("abort no_done", done_cnt, 0);
    $display("op abort: done/busy cycles after abort=%0d", done_cnt);

    // CHUNK=16 and CHUNK=1 instances
    run_op(1, "chunk16", 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1, 1'b0);
    run_op(2, "chunk1",  16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 16, 1'b0);
    run_op(2, "chunk1_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
